// File: rtl/issue_queue_pkg.sv
// Shared constants and micro-op encodings for the out-of-order issue path.
// The constants give the default widths of the issue queue parameters.
package issue_queue_pkg;

  localparam int TYPE_BIT      = 6;
  localparam int ROB_INDEX_BIT = 4;
  localparam int XLEN          = 32;

  // Bit 4 separates branch compares from plain ALU operations.
  typedef enum logic [TYPE_BIT-1:0] {
    UOP_ADD  = 6'd0,
    UOP_SUB  = 6'd1,
    UOP_AND  = 6'd2,
    UOP_OR   = 6'd3,
    UOP_XOR  = 6'd4,
    UOP_SLL  = 6'd5,
    UOP_SRL  = 6'd6,
    UOP_SRA  = 6'd7,
    UOP_SLT  = 6'd8,
    UOP_SLTU = 6'd9,
    UOP_BEQ  = 6'd16,
    UOP_BNE  = 6'd17,
    UOP_BLT  = 6'd18,
    UOP_BGE  = 6'd19,
    UOP_BLTU = 6'd20,
    UOP_BGEU = 6'd21
  } uop_e;

  function automatic logic is_branch(input logic [TYPE_BIT-1:0] op);
    return op[4];
  endfunction

endpackage

// File: rtl/iq_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
// age[i*DEPTH+j] = 1 means entry i is older than entry j.
module iq_age_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]       ready,
  input  logic [DEPTH*DEPTH-1:0] age,
  output logic [DEPTH-1:0]       grant,
  output logic                   any_grant
);
  import issue_queue_pkg::*;

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && age[j*DEPTH + i]) grant[i] = 1'b0;
      end
    end
  end

  assign any_grant = |ready;

endmodule

// File: rtl/issue_queue.sv
// Age-ordered issue queue: holds micro-ops until both operands arrive over the CDBs,
// then issues the oldest ready one through a registered valid/ready port.
module issue_queue #(
  parameter int DEPTH   = 8,
  parameter int TAG_W   = issue_queue_pkg::ROB_INDEX_BIT,
  parameter int OP_W    = issue_queue_pkg::TYPE_BIT,
  parameter int XLEN    = issue_queue_pkg::XLEN,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush,
  input  logic                     ins_valid,
  output logic                     ins_ready,
  input  logic [OP_W-1:0]          ins_op,
  input  logic [TAG_W-1:0]         ins_rob_id,
  input  logic [XLEN-1:0]          ins_v1,
  input  logic [XLEN-1:0]          ins_v2,
  input  logic [TAG_W-1:0]         ins_q1,
  input  logic [TAG_W-1:0]         ins_q2,
  input  logic                     ins_has_dep1,
  input  logic                     ins_has_dep2,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [TAG_W-1:0]         iss_rob_id,
  output logic [XLEN-1:0]          iss_v1,
  output logic [XLEN-1:0]          iss_v2,
  output logic [$clog2(DEPTH):0]   occupancy
);
  import issue_queue_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic [DEPTH-1:0]       ent_vld, ent_dep1, ent_dep2;
  logic [OP_W-1:0]        ent_op  [DEPTH];
  logic [TAG_W-1:0]       ent_rob [DEPTH];
  logic [TAG_W-1:0]       ent_q1  [DEPTH];
  logic [TAG_W-1:0]       ent_q2  [DEPTH];
  logic [XLEN-1:0]        ent_v1  [DEPTH];
  logic [XLEN-1:0]        ent_v2  [DEPTH];
  logic [DEPTH*DEPTH-1:0] age;

  logic [XLEN:0]    wake1 [DEPTH];
  logic [XLEN:0]    wake2 [DEPTH];
  logic [XLEN:0]    cap1, cap2;
  logic [DEPTH-1:0] rdy_vec, grant;
  logic             any_grant, advance, issue_fire, insert;
  logic [IDX_W-1:0] sel_idx, ins_idx;
  logic [OCC_W-1:0] occ_next;
  logic             vld_p1;

  // Returns {hit, value}; the lowest matching channel wins if tags collide.
  function automatic logic [XLEN:0] cdb_match(
    input logic [TAG_W-1:0]         tag,
    input logic [NUM_CDB-1:0]       bus_vld,
    input logic [NUM_CDB*TAG_W-1:0] bus_tag,
    input logic [NUM_CDB*XLEN-1:0]  bus_val
  );
    logic [XLEN:0] hit;
    hit = '0;
    for (int c = NUM_CDB-1; c >= 0; c--) begin
      if (bus_vld[c] && bus_tag[c*TAG_W +: TAG_W] == tag)
        hit = {1'b1, bus_val[c*XLEN +: XLEN]};
    end
    return hit;
  endfunction

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    assign wake1[g]   = cdb_match(ent_q1[g], cdb_valid, cdb_tag, cdb_val);
    assign wake2[g]   = cdb_match(ent_q2[g], cdb_valid, cdb_tag, cdb_val);
    assign rdy_vec[g] = ent_vld[g] & ~ent_dep1[g] & ~ent_dep2[g];
  end

  assign cap1 = cdb_match(ins_q1, cdb_valid, cdb_tag, cdb_val);
  assign cap2 = cdb_match(ins_q2, cdb_valid, cdb_tag, cdb_val);

  iq_age_select #(.DEPTH(DEPTH)) u_select (
    .ready     (rdy_vec),
    .age       (age),
    .grant     (grant),
    .any_grant (any_grant)
  );

  always_comb begin
    sel_idx = '0;
    ins_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!ent_vld[i]) ins_idx = IDX_W'(i);
      if (grant[i])    sel_idx = IDX_W'(i);
    end
  end

  assign insert     = ins_valid & ins_ready;
  assign advance    = ~vld_p1 | iss_ready;
  assign issue_fire = advance & any_grant;
  assign occ_next   = occupancy + OCC_W'(insert) - OCC_W'(issue_fire);
  assign iss_valid  = vld_p1;

  // Entry payload and operand wake-up; validity is tracked separately below.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_dep1[i] && wake1[i][XLEN]) begin
          ent_dep1[i] <= 1'b0;
          ent_v1[i]   <= wake1[i][XLEN-1:0];
        end
        if (ent_dep2[i] && wake2[i][XLEN]) begin
          ent_dep2[i] <= 1'b0;
          ent_v2[i]   <= wake2[i][XLEN-1:0];
        end
      end
      if (insert) begin
        ent_op[ins_idx]   <= ins_op;
        ent_rob[ins_idx]  <= ins_rob_id;
        ent_q1[ins_idx]   <= ins_q1;
        ent_q2[ins_idx]   <= ins_q2;
        ent_dep1[ins_idx] <= ins_has_dep1 & ~cap1[XLEN];
        ent_dep2[ins_idx] <= ins_has_dep2 & ~cap2[XLEN];
        ent_v1[ins_idx]   <= (ins_has_dep1 & cap1[XLEN]) ? cap1[XLEN-1:0] : ins_v1;
        ent_v2[ins_idx]   <= (ins_has_dep2 & cap2[XLEN]) ? cap2[XLEN-1:0] : ins_v2;
      end
    end
  end

  // Stage p1: issue register, loaded from the granted entry as it is freed.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush) begin
      ent_vld    <= '0;
      age        <= '0;
      vld_p1     <= 1'b0;
      iss_op     <= '0;
      iss_rob_id <= '0;
      iss_v1     <= '0;
      iss_v2     <= '0;
      occupancy  <= '0;
      ins_ready  <= 1'b1;
    end else if (rdy_in) begin
      if (issue_fire) ent_vld[sel_idx] <= 1'b0;
      if (insert) begin
        ent_vld[ins_idx] <= 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
          age[int'(ins_idx)*DEPTH + j] <= 1'b0;
          age[j*DEPTH + int'(ins_idx)] <= ent_vld[j];
        end
      end
      if (advance) begin
        vld_p1 <= any_grant;
        if (any_grant) begin
          iss_op     <= ent_op[sel_idx];
          iss_rob_id <= ent_rob[sel_idx];
          iss_v1     <= ent_v1[sel_idx];
          iss_v2     <= ent_v2[sel_idx];
        end
      end
      occupancy <= occ_next;
      ins_ready <= (occ_next < OCC_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic, scored against an
// age-ordered list model of the queue and a queue of expected issues.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  localparam int OP_W  = 6;
  localparam int XW    = 32;
  localparam int NCDB  = 2;

  logic                  clk_in = 1'b0;
  logic                  rst_in, rdy_in, flush;
  logic                  ins_valid, ins_ready;
  logic [OP_W-1:0]       ins_op;
  logic [TAG_W-1:0]      ins_rob_id, ins_q1, ins_q2;
  logic [XW-1:0]         ins_v1, ins_v2;
  logic                  ins_has_dep1, ins_has_dep2;
  logic [NCDB-1:0]       cdb_valid;
  logic [NCDB*TAG_W-1:0] cdb_tag;
  logic [NCDB*XW-1:0]    cdb_val;
  logic                  iss_valid, iss_ready;
  logic [OP_W-1:0]       iss_op;
  logic [TAG_W-1:0]      iss_rob_id;
  logic [XW-1:0]         iss_v1, iss_v2;
  logic [3:0]            occupancy;

  always #5 clk_in = ~clk_in;

  issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .XLEN(XW), .NUM_CDB(NCDB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op), .ins_rob_id(ins_rob_id),
    .ins_v1(ins_v1), .ins_v2(ins_v2), .ins_q1(ins_q1), .ins_q2(ins_q2),
    .ins_has_dep1(ins_has_dep1), .ins_has_dep2(ins_has_dep2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_rob_id(iss_rob_id),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .occupancy(occupancy)
  );

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] rob;
    logic [XW-1:0]    v1, v2;
    logic [TAG_W-1:0] q1, q2;
    logic             d1, d2;
  } uop_t;

  uop_t mq[$];   // waiting micro-ops, oldest at index 0
  uop_t sb[$];   // expected issue stream
  logic m_iss_valid = 1'b0;
  logic m_ins_ready = 1'b1;
  int   m_occ = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  int         pick;
  logic       hit;
  logic [XW-1:0] hv;
  uop_t       ne, e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void bus_lookup(input logic [TAG_W-1:0] tag, output logic h, output logic [XW-1:0] v);
    h = 1'b0;
    v = '0;
    for (int c = 0; c < NCDB; c++) begin
      if (!h && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == tag) begin
        h = 1'b1;
        v = cdb_val[c*XW +: XW];
      end
    end
  endfunction

  // Reference model: one step per clock edge, from the values present at that edge.
  always @(posedge clk_in) begin
    if (rst_in || flush) begin
      mq.delete();
      sb.delete();
      m_iss_valid = 1'b0;
      m_ins_ready = 1'b1;
      m_occ       = 0;
    end else if (rdy_in) begin
      if (!m_iss_valid || iss_ready) begin
        pick = -1;
        for (int i = 0; i < mq.size(); i++)
          if (pick < 0 && !mq[i].d1 && !mq[i].d2) pick = i;
        if (pick >= 0) begin
          sb.push_back(mq[pick]);
          mq.delete(pick);
        end
        m_iss_valid = (pick >= 0);
      end
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (e.d1) begin
          bus_lookup(e.q1, hit, hv);
          if (hit) begin e.d1 = 1'b0; e.v1 = hv; end
        end
        if (e.d2) begin
          bus_lookup(e.q2, hit, hv);
          if (hit) begin e.d2 = 1'b0; e.v2 = hv; end
        end
        mq[i] = e;
      end
      if (ins_valid && m_ins_ready) begin
        ne.op = ins_op; ne.rob = ins_rob_id; ne.v1 = ins_v1; ne.v2 = ins_v2;
        ne.q1 = ins_q1; ne.q2 = ins_q2; ne.d1 = ins_has_dep1; ne.d2 = ins_has_dep2;
        if (ne.d1) begin
          bus_lookup(ne.q1, hit, hv);
          if (hit) begin ne.d1 = 1'b0; ne.v1 = hv; end
        end
        if (ne.d2) begin
          bus_lookup(ne.q2, hit, hv);
          if (hit) begin ne.d2 = 1'b0; ne.v2 = hv; end
        end
        mq.push_back(ne);
      end
      m_occ       = mq.size();
      m_ins_ready = (m_occ < DEPTH);
    end
  end

  // Monitor: compares status every cycle and the payload against the scoreboard head.
  always @(negedge clk_in) begin
    if (mon_en) begin
      chk("iss_valid", 64'(iss_valid), 64'(m_iss_valid));
      chk("occupancy", 64'(occupancy), 64'(m_occ));
      chk("ins_ready", 64'(ins_ready), 64'(m_ins_ready));
      if (iss_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL iss_unexpected actual=rob %0d required=no issue pending", iss_rob_id);
        end else begin
          chk("iss_rob_id", 64'(iss_rob_id), 64'(sb[0].rob));
          chk("iss_op", 64'(iss_op), 64'(sb[0].op));
          chk("iss_v1", 64'(iss_v1), 64'(sb[0].v1));
          chk("iss_v2", 64'(iss_v2), 64'(sb[0].v2));
          if (iss_ready && rdy_in && !flush && !rst_in) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic insert(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] rob,
                        input logic [XW-1:0] v1, input logic [XW-1:0] v2,
                        input logic [TAG_W-1:0] q1, input logic [TAG_W-1:0] q2,
                        input logic d1, input logic d2);
    int waited;
    waited = 0;
    while (!m_ins_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!m_ins_ready) begin
      checks++;
      errors++;
      $display("FAIL insert_wait actual=ins_ready low required=high within 50 cycles");
    end else begin
      ins_op = op; ins_rob_id = rob; ins_v1 = v1; ins_v2 = v2;
      ins_q1 = q1; ins_q2 = q2; ins_has_dep1 = d1; ins_has_dep2 = d2;
      ins_valid = 1'b1;
      step();
      ins_valid = 1'b0;
    end
  endtask

  task automatic bcast(input int ch, input logic [TAG_W-1:0] tag, input logic [XW-1:0] val);
    cdb_valid[ch]               = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W]  = tag;
    cdb_val[ch*XW +: XW]        = val;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout actual=still running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; iss_ready = 1'b1;
    ins_valid = 1'b0; ins_op = '0; ins_rob_id = '0; ins_v1 = '0; ins_v2 = '0;
    ins_q1 = '0; ins_q2 = '0; ins_has_dep1 = 1'b0; ins_has_dep2 = 1'b0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    idle(2);
    rst_in = 1'b0;
    mon_en = 1'b1;
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_ins_ready", 64'(ins_ready), 64'd1);
    chk("rst_iss_op", 64'(iss_op), 64'd0);
    chk("rst_iss_rob", 64'(iss_rob_id), 64'd0);
    chk("rst_iss_v1", 64'(iss_v1), 64'd0);
    chk("rst_iss_v2", 64'(iss_v2), 64'd0);

    // Three independent ADDs issue in order.
    insert(UOP_ADD, 4'd1, 32'd10, 32'd11, 4'd0, 4'd0, 1'b0, 1'b0);
    insert(UOP_ADD, 4'd2, 32'd20, 32'd21, 4'd0, 4'd0, 1'b0, 1'b0);
    insert(UOP_ADD, 4'd3, 32'd30, 32'd31, 4'd0, 4'd0, 1'b0, 1'b0);
    idle(5);

    // Younger ready op overtakes an older one waiting on tag 9.
    insert(UOP_SUB, 4'd5, 32'd0, 32'd7, 4'd9, 4'd0, 1'b1, 1'b0);
    insert(UOP_ADD, 4'd6, 32'd1, 32'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    bcast(1, 4'd9, 32'h1234);
    step();
    cdb_valid = '0;
    idle(4);

    // Same-cycle capture on insert.
    bcast(0, 4'd4, 32'hDEAD);
    insert(UOP_AND, 4'd7, 32'd3, 32'd0, 4'd0, 4'd4, 1'b0, 1'b1);
    cdb_valid = '0;
    idle(3);

    // Fill while stalled, then drain.
    iss_ready = 1'b0;
    for (int n = 0; n < DEPTH + 1; n++)
      insert(UOP_OR, TAG_W'(n), $urandom, $urandom, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("full_occupancy", 64'(occupancy), 64'd8);
    chk("full_ins_ready", 64'(ins_ready), 64'd0);
    idle(2);
    iss_ready = 1'b1;
    idle(12);

    // Two channels wake two entries together; older goes first.
    insert(UOP_XOR, 4'd10, 32'd0, 32'd5, 4'd2, 4'd0, 1'b1, 1'b0);
    insert(UOP_SLL, 4'd11, 32'd0, 32'd6, 4'd3, 4'd0, 1'b1, 1'b0);
    idle(1);
    bcast(0, 4'd3, 32'h3333);
    bcast(1, 4'd2, 32'h2222);
    step();
    cdb_valid = '0;
    idle(4);

    // Flush during a stall, then freeze with rdy_in low.
    iss_ready = 1'b0;
    for (int n = 0; n < 6; n++)
      insert(UOP_BEQ, TAG_W'(n + 8), $urandom, $urandom, 4'd0, 4'd0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_iss_valid", 64'(iss_valid), 64'd0);
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    chk("flush_ins_ready", 64'(ins_ready), 64'd1);
    iss_ready = 1'b1;
    insert(UOP_BNE, 4'd12, 32'd1, 32'd2, 4'd15, 4'd0, 1'b1, 1'b0);
    insert(UOP_BLT, 4'd13, 32'd3, 32'd4, 4'd0, 4'd15, 1'b0, 1'b1);
    rdy_in = 1'b0;
    ins_valid = 1'b1; ins_rob_id = 4'd14; ins_has_dep1 = 1'b0; ins_has_dep2 = 1'b0;
    bcast(0, 4'd15, 32'hBEEF);
    idle(3);
    rdy_in = 1'b1;
    ins_valid = 1'b0;
    cdb_valid = '0;
    chk("freeze_occupancy", 64'(occupancy), 64'd2);
    chk("freeze_iss_valid", 64'(iss_valid), 64'd0);
    bcast(1, 4'd15, 32'hCAFE);
    step();
    cdb_valid = '0;
    idle(5);

    // Random traffic.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      iss_ready    = ($urandom_range(0, 3) != 0);
      rdy_in       = ($urandom_range(0, 15) != 0);
      flush        = ($urandom_range(0, 149) == 0);
      ins_valid    = m_ins_ready && ($urandom_range(0, 1) == 1);
      ins_op       = OP_W'($urandom_range(0, 21));
      ins_rob_id   = TAG_W'($urandom);
      ins_v1       = $urandom;
      ins_v2       = $urandom;
      ins_q1       = TAG_W'($urandom);
      ins_q2       = TAG_W'($urandom);
      ins_has_dep1 = ($urandom_range(0, 2) == 0);
      ins_has_dep2 = ($urandom_range(0, 2) == 0);
      cdb_valid    = NCDB'($urandom);
      cdb_tag      = NCDB*TAG_W'($urandom);
      if (cdb_tag[7:4] == cdb_tag[3:0]) cdb_tag[7:4] = cdb_tag[3:0] + 4'd1;
      cdb_val      = {$urandom, $urandom};
      step();
    end

    // Broadcast every tag once so everything left can drain.
    flush = 1'b0; rdy_in = 1'b1; iss_ready = 1'b1; ins_valid = 1'b0;
    for (int t = 0; t < 8; t++) begin
      cdb_valid = '0;
      bcast(0, TAG_W'(2 * t), $urandom);
      bcast(1, TAG_W'(2 * t + 1), $urandom);
      step();
    end
    cdb_valid = '0;
    idle(20);
    chk("drain_occupancy", 64'(occupancy), 64'd0);
    chk("drain_iss_valid", 64'(iss_valid), 64'd0);
    chk("drain_ins_ready", 64'(ins_ready), 64'd1);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Parametrised successor to the single-CDB reservation station.
- Holds dispatched ALU/branch micro-ops until both operands are available, then issues them oldest-first through a registered valid/ready port to a downstream execution unit.
- Generalised depth and tag width; NUM_CDB parallel broadcast channels for wake-up; age-ordered selection; downstream backpressure; flush.
- Sits between the dispatch stage (fed from RF/ROB rename lookups) and the ALU. The ALU writes results back to the ROB.

Parameters:
- DEPTH, 8, entries; power of two, >=2.
- TAG_W, 4, ROB index width.
- OP_W, 6, micro-op type width (shared TYPE_BIT).
- XLEN, 32, operand width.
- NUM_CDB, 2, number of CDB broadcast channels.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  global enable; low = freeze all state
- flush  in  1  mispredict clear; synchronous, same effect as reset
- ins_valid  in  1  dispatch request
- ins_ready  out  1  registered; high = at least one free entry
- ins_op  in  OP_W  normalised micro-op (immediates already folded by dispatch)
- ins_rob_id  in  TAG_W  destination tag
- ins_v1 / ins_v2  in  XLEN each  operand values
- ins_q1 / ins_q2  in  TAG_W each  producer tags
- ins_has_dep1 / ins_has_dep2  in  1 each  operand not yet available
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  packed tags, channel 0 in LSBs
- cdb_val  in  NUM_CDB*XLEN  packed values
- iss_valid  out  1  registered issue valid
- iss_ready  in  1  downstream accepts
- iss_op  out  OP_W
- iss_rob_id  out  TAG_W
- iss_v1 / iss_v2  out  XLEN each
- occupancy  out  $clog2(DEPTH)+1  registered entry count

Behaviour:
- Reset/flush (priority over rdy_in): all entries invalid, age matrix cleared, iss_valid=0, iss_* payload=0, occupancy=0, ins_ready=1.
- rdy_in low: no state change. CDB producers are frozen by the same signal, so no broadcasts are lost.
- Entry fields: valid, op, rob_id, v1, v2, q1, q2, dep1, dep2.
- Insert: on ins_valid & ins_ready, write to the lowest-index free entry.
  - Same-cycle capture: if depN and any channel has cdb_valid & cdb_tag==qN, store that cdb_val and clear depN.
  - ins_valid while !ins_ready is ignored; the bench asserts this never happens.
- Wake-up: for each valid entry with depN=1, any channel matching qN sets vN=cdb_val and depN=0.
  - Entries with depN=0 are never overwritten.
  - Two channels carrying the same tag in one cycle is illegal; if it occurs, the lowest channel wins.
- Age: an N×N age matrix, where bit[i][j]=1 means i is older than j.
  - On insert to k: row k cleared; column k set for all currently valid entries.
- Ready(i) = valid & !dep1 & !dep2, evaluated on registered state. A wake-up lands on edge E; the entry is selectable on edge E+1.
- Select: the ready entry with no older ready entry (one-hot).
- Issue register advance condition: !iss_valid | iss_ready.
  - On advance with a selected entry: load iss_* from it, set iss_valid=1, free the entry the same edge.
  - On advance with no selection: iss_valid=0.
  - While stalled (iss_valid & !iss_ready): hold iss_* stable, free nothing.
- Latency: an entry inserted with no deps at edge E0 gives iss_valid high after edge E0+1 (when not stalled).
- An entry may be freed and a new one inserted in the same cycle.
- occupancy_next = occupancy + insert − issue.
- ins_ready registered: occupancy_next < DEPTH.
- Full boundary: after the DEPTH-th insert, ins_ready drops the next cycle. An issue in the same cycle keeps ins_ready high.

Decomposition:
- Shared package/const: OP_W (TYPE_BIT), micro-op encodings, ROB_INDEX_BIT, XLEN.
- One sub-module: iq_age_select. Inputs: ready vector and age matrix. Output: one-hot grant plus any_grant. Purely combinational; kept separate so it can be unit-tested.
- Entry storage, wake-up, and the issue register live in issue_queue.

Test Plan:
- Reset then insert 3 independent ADDs (rob 1,2,3) back-to-back, iss_ready=1 → issue order rob 1,2,3 on consecutive cycles; first iss_valid two cycles after the first insert.
- Insert rob 5 (dep1 on tag 9), then rob 6 (ready); broadcast tag 9 val 0x1234 on channel 1 → rob 6 issues first; rob 5 issues with v1=0x1234 on the cycle after the wake-up.
- Insert an entry with dep2 on tag 4 while channel 0 broadcasts tag 4 val 0xDEAD the same cycle → entry stores 0xDEAD, dep2=0, issues the next cycle.
- Hold iss_ready=0 while filling all 8 entries → iss_* stable; ins_ready=0 after the 8th insert (occupancy=8; the held entry is in the issue register); release → drains oldest-first.
- Two channels wake two different entries in one cycle (tags 2, 3) → both become ready; the older one issues first.
- Flush asserted mid-stall with 5 entries → next cycle iss_valid=0, occupancy=0, ins_ready=1; rdy_in=0 for 3 cycles → no state change.
